camera_frame_dma: RTL and testbench



---
 rtl/camera_pkg.sv | 20 ++
 rtl/camera_frame_dma.sv | 170 +++++++++++++++++
 tb/tb_camera_frame_dma.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/camera_pkg.sv
// Shared types and geometry for the camera capture-to-memory path.
// One FIFO entry is 128 bits, written to memory as four 32-bit beats.
package camera_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_BEAT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int BEATS_PER_ENTRY = 4;
  localparam int ENTRY_BYTES     = 16;
  localparam int WORD_W          = 32;
  localparam int ENTRY_W         = WORD_W * BEATS_PER_ENTRY;
  localparam int BEAT_W          = $clog2(BEATS_PER_ENTRY);
  localparam int ALIGN_W         = $clog2(ENTRY_BYTES);
  localparam int BEAT_BYTES      = WORD_W / 8;

endpackage

// File: rtl/camera_frame_dma.sv
// Drains the capture FIFO and writes each frame to memory as 32-bit beats
// over a req/ack port, handling frame length, restarts and clean stop.
module camera_frame_dma
  import camera_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                HCLK,
  input  logic                HReset_N,
  input  logic                i_Enable,
  input  logic [ADDR_W-1:0]   i_BaseAddr,
  input  logic [CNT_W-1:0]    i_FrameLen,
  input  logic                i_ZoneReStart,
  input  logic                i_FIFOEmpty,
  output logic                o_ReadEn,
  input  logic [ENTRY_W-1:0]  i_RdData,
  output logic                o_MemReq,
  output logic [ADDR_W-1:0]   o_MemAddr,
  output logic [WORD_W-1:0]   o_MemWData,
  input  logic                i_MemAck,
  output logic                o_FrameDone,
  output logic                o_FrameAbort,
  output logic                o_Busy
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [ENTRY_W-1:0]   hold_q, hold_d;
  logic                 pend_q, pend_d;
  logic                 abort_q, abort_d;

  logic                 pop;
  logic                 ack;
  logic                 last_beat;
  logic                 frame_end;
  logic                 restart_now;
  logic                 reload;
  logic [CNT_W-1:0]     cnt_inc;
  logic [ADDR_W-1:0]    base_aligned;
  logic [WORD_W-1:0]    word_w [BEATS_PER_ENTRY];
  logic                 unused_base_low;

  // Entries are 16-byte aligned; the low address bits of the base are dropped.
  assign base_aligned    = {i_BaseAddr[ADDR_W-1:ALIGN_W], {ALIGN_W{1'b0}}};
  assign unused_base_low = ^i_BaseAddr[ALIGN_W-1:0];

  assign pop         = (state_q == ST_FETCH) && !i_FIFOEmpty;
  assign ack         = (state_q == ST_BEAT) && i_MemAck;
  assign last_beat   = (beat_q == BEAT_W'(BEATS_PER_ENTRY - 1));
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign frame_end   = (cnt_inc == len_q);
  assign restart_now = pend_q || i_ZoneReStart;

  for (genvar gi = 0; gi < BEATS_PER_ENTRY; gi++) begin : g_word
    assign word_w[gi] = hold_q[gi*WORD_W +: WORD_W];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    abort_d = 1'b0;
    reload  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_Enable && i_ZoneReStart) begin
          reload  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (i_ZoneReStart) begin
          abort_d = 1'b1;
          reload  = 1'b1;
        end
        // A pop in the restart cycle becomes the first entry of the new frame.
        if (pop) begin
          hold_d  = i_RdData;
          beat_d  = '0;
          state_d = ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (ack) begin
          addr_d = addr_q + ADDR_W'(BEAT_BYTES);
          if (last_beat) begin
            cnt_d = cnt_inc;
            if (frame_end) begin
              // Completion beats a coincident restart; the restart is kept for DONE.
              pend_d  = restart_now;
              state_d = ST_DONE;
            end else if (restart_now) begin
              abort_d = 1'b1;
              reload  = 1'b1;
              state_d = ST_FETCH;
            end else if (!i_Enable) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_FETCH;
            end
          end else if (restart_now) begin
            abort_d = 1'b1;
            reload  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (i_ZoneReStart) begin
          pend_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (restart_now) begin
          reload  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reload) begin
      addr_d = base_aligned;
      cnt_d  = '0;
      len_d  = i_FrameLen;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HReset_N) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      abort_q <= abort_d;
    end
  end

  assign o_ReadEn     = pop;
  assign o_MemReq     = (state_q == ST_BEAT);
  assign o_MemAddr    = addr_q;
  assign o_MemWData   = word_w[beat_q];
  assign o_FrameDone  = (state_q == ST_DONE);
  assign o_FrameAbort = abort_q;
  assign o_Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_camera_frame_dma.sv
// Self-checking bench for camera_frame_dma: FIFO and memory-port models,
// a beat scoreboard, a table of whole-frame vectors and restart/stop/reset corners.
module tb_camera_frame_dma;

  logic          HCLK = 1'b0;
  logic          HReset_N = 1'b0;
  logic          i_Enable = 1'b0;
  logic [31:0]   i_BaseAddr = '0;
  logic [15:0]   i_FrameLen = '0;
  logic          i_ZoneReStart;
  logic          i_FIFOEmpty = 1'b1;
  logic          o_ReadEn;
  logic [127:0]  i_RdData = '0;
  logic          o_MemReq;
  logic [31:0]   o_MemAddr;
  logic [31:0]   o_MemWData;
  logic          i_MemAck = 1'b0;
  logic          o_FrameDone;
  logic          o_FrameAbort;
  logic          o_Busy;

  logic          restart_main = 1'b0;
  logic          restart_mon = 1'b0;
  assign i_ZoneReStart = restart_main | restart_mon;

  always #5 HCLK = ~HCLK;

  camera_frame_dma #(.ADDR_W(32), .CNT_W(16)) dut (
    .HCLK          (HCLK),
    .HReset_N      (HReset_N),
    .i_Enable      (i_Enable),
    .i_BaseAddr    (i_BaseAddr),
    .i_FrameLen    (i_FrameLen),
    .i_ZoneReStart (i_ZoneReStart),
    .i_FIFOEmpty   (i_FIFOEmpty),
    .o_ReadEn      (o_ReadEn),
    .i_RdData      (i_RdData),
    .o_MemReq      (o_MemReq),
    .o_MemAddr     (o_MemAddr),
    .o_MemWData    (o_MemWData),
    .i_MemAck      (i_MemAck),
    .o_FrameDone   (o_FrameDone),
    .o_FrameAbort  (o_FrameAbort),
    .o_Busy        (o_Busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    int          n_entries;
    int          ack_dly;
    int          gap;
    int          exp_beats;
    int          exp_done;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [127:0] fifo_q[$];
  beat_t        sb[$];
  bit           pop_flag = 1'b0;
  int           gap_cnt = 0;
  int           fifo_gap = 0;
  int           ack_delay = 0;
  int           wait_cnt = 0;
  int           beats_seen = 0;
  int           done_cnt = 0;
  int           abort_cnt = 0;
  int           cyc = 0;
  int           last_ack_cyc = -10;
  int           restart_at_beat = -1;
  bit           prev_wait = 1'b0;
  logic [31:0]  prev_addr = '0;
  logic [31:0]  prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_entry(input logic [31:0] eaddr, input int nbeats);
    logic [127:0] d;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    fifo_q.push_back(d);
    for (int b = 0; b < nbeats; b++)
      sb.push_back('{eaddr + 32'(4 * b), d[b*32 +: 32]});
  endtask

  // FIFO and memory-port models: drive at the falling edge, sample 1 ns later.
  always @(negedge HCLK) begin
    logic [127:0] tmp;
    beat_t        exp_b;
    if (pop_flag) begin
      if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
      gap_cnt  = fifo_gap;
      pop_flag = 1'b0;
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
    i_FIFOEmpty = (fifo_q.size() == 0) || (gap_cnt > 0);
    i_RdData    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    restart_mon = 1'b0;
    if (o_MemReq && wait_cnt >= ack_delay) begin
      i_MemAck = 1'b1;
      if (restart_at_beat == beats_seen) restart_mon = 1'b1;
    end else begin
      i_MemAck = 1'b0;
    end
    #1;
    cyc++;
    if (o_ReadEn) begin
      chk("readen_while_empty", 64'(i_FIFOEmpty), 64'd0);
      pop_flag = 1'b1;
    end
    if (o_MemReq && i_MemAck) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr %08h data %08h, expected no beat", o_MemAddr, o_MemWData);
      end else begin
        exp_b = sb.pop_front();
        chk("beat_addr", 64'(o_MemAddr), 64'(exp_b.addr));
        chk("beat_data", 64'(o_MemWData), 64'(exp_b.data));
      end
      $display("beat %0d addr=%08h data=%08h", beats_seen, o_MemAddr, o_MemWData);
      beats_seen++;
      last_ack_cyc = cyc;
      wait_cnt = 0;
    end else if (o_MemReq) begin
      if (prev_wait) begin
        chk("req_hold_addr", 64'(o_MemAddr), 64'(prev_addr));
        chk("req_hold_data", 64'(o_MemWData), 64'(prev_data));
      end
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    prev_wait = o_MemReq && !i_MemAck;
    prev_addr = o_MemAddr;
    prev_data = o_MemWData;
    if (o_FrameDone) begin
      done_cnt++;
      chk("done_latency", 64'(cyc), 64'(last_ack_cyc + 1));
      $display("frame done at cycle %0d", cyc);
    end
    if (o_FrameAbort) begin
      abort_cnt++;
      $display("frame abort at cycle %0d", cyc);
    end
  end

  task automatic pulse_restart();
    @(negedge HCLK);
    restart_main = 1'b1;
    @(negedge HCLK);
    restart_main = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      #2;
      n++;
    end while (o_Busy && n < budget);
    chk({tag, "_idle"}, 64'(o_Busy), 64'd0);
  endtask

  task automatic wait_beats(input int target, input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      #2;
      n++;
    end while (beats_seen < target && n < budget);
    if (beats_seen < target) chk({tag, "_beat_timeout"}, 64'(beats_seen), 64'(target));
  endtask

  task automatic wait_req(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      #2;
      n++;
    end while (!o_MemReq && n < budget);
    if (!o_MemReq) chk({tag, "_req_timeout"}, 64'(o_MemReq), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_readen"}, 64'(o_ReadEn), 64'd0);
    chk({tag, "_memreq"}, 64'(o_MemReq), 64'd0);
    chk({tag, "_done"},   64'(o_FrameDone), 64'd0);
    chk({tag, "_abort"},  64'(o_FrameAbort), 64'd0);
    chk({tag, "_busy"},   64'(o_Busy), 64'd0);
    chk({tag, "_addr"},   64'(o_MemAddr), 64'd0);
    chk({tag, "_wdata"},  64'(o_MemWData), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt[5];
    logic [31:0] eaddr;
    int          b0, d0, a0;

    vt[0] = '{32'h1000_0000, 16'd2, 2, 0, 0,  8, 1};
    vt[1] = '{32'h1000_0000, 16'd2, 2, 3, 10, 8, 1};
    vt[2] = '{32'h2000_0007, 16'd1, 1, 1, 0,  4, 1};
    vt[3] = '{32'hFFFF_FFE0, 16'd3, 3, 0, 2, 12, 1};
    vt[4] = '{32'h0000_ABC0, 16'd3, 3, 2, 0, 12, 1};

    repeat (3) @(negedge HCLK);
    #2;
    chk_reset_outputs("reset");
    @(negedge HCLK);
    HReset_N = 1'b1;
    i_Enable = 1'b1;
    repeat (2) @(negedge HCLK);

    for (int v = 0; v < 5; v++) begin
      @(negedge HCLK);
      $display("vector %0d base=%08h len=%0d ack_dly=%0d gap=%0d", v, vt[v].base, vt[v].len, vt[v].ack_dly, vt[v].gap);
      ack_delay  = vt[v].ack_dly;
      fifo_gap   = vt[v].gap;
      i_BaseAddr = vt[v].base;
      i_FrameLen = vt[v].len;
      b0 = beats_seen; d0 = done_cnt; a0 = abort_cnt;
      eaddr = {vt[v].base[31:4], 4'h0};
      for (int e = 0; e < vt[v].n_entries; e++) add_entry(eaddr + 32'(16 * e), 4);
      restart_main = 1'b1;
      @(negedge HCLK);
      restart_main = 1'b0;
      #2;
      chk($sformatf("v%0d_restart_to_readen", v), 64'(o_ReadEn), 64'd1);
      @(negedge HCLK);
      #2;
      chk($sformatf("v%0d_pop_to_req", v), 64'(o_MemReq), 64'd1);
      wait_idle(3000, $sformatf("v%0d", v));
      chk($sformatf("v%0d_beats", v), 64'(beats_seen - b0), 64'(vt[v].exp_beats));
      chk($sformatf("v%0d_done", v), 64'(done_cnt - d0), 64'(vt[v].exp_done));
      chk($sformatf("v%0d_abort", v), 64'(abort_cnt - a0), 64'd0);
      chk($sformatf("v%0d_sb_left", v), 64'(sb.size()), 64'd0);
    end

    // Restart during beat 1 of the first entry.
    $display("corner: restart during beat 1, len=4");
    ack_delay = 2; fifo_gap = 0;
    i_BaseAddr = 32'h3000_0000; i_FrameLen = 16'd4;
    b0 = beats_seen; d0 = done_cnt; a0 = abort_cnt;
    add_entry(32'h3000_0000, 2);
    for (int e = 0; e < 4; e++) add_entry(32'h3000_0000 + 32'(16 * e), 4);
    pulse_restart();
    wait_beats(b0 + 1, 100, "abort");
    @(negedge HCLK);
    restart_main = 1'b1;
    @(negedge HCLK);
    restart_main = 1'b0;
    wait_idle(2000, "abort");
    chk("abort_beats", 64'(beats_seen - b0), 64'd18);
    chk("abort_pulses", 64'(abort_cnt - a0), 64'd1);
    chk("abort_done", 64'(done_cnt - d0), 64'd1);
    chk("abort_sb_left", 64'(sb.size()), 64'd0);

    // Restart coincident with the final ack of a one-entry frame.
    $display("corner: restart on final ack");
    ack_delay = 0;
    i_BaseAddr = 32'h4000_0100; i_FrameLen = 16'd1;
    b0 = beats_seen; d0 = done_cnt; a0 = abort_cnt;
    add_entry(32'h4000_0100, 4);
    add_entry(32'h4000_0100, 4);
    restart_at_beat = beats_seen + 3;
    pulse_restart();
    wait_beats(b0 + 4, 100, "coinc");
    restart_at_beat = -1;
    wait_idle(2000, "coinc");
    chk("coinc_beats", 64'(beats_seen - b0), 64'd8);
    chk("coinc_done", 64'(done_cnt - d0), 64'd2);
    chk("coinc_abort", 64'(abort_cnt - a0), 64'd0);
    chk("coinc_sb_left", 64'(sb.size()), 64'd0);

    // Enable dropped during beat 0; later restart while disabled is ignored.
    $display("corner: enable drop during beat 0");
    ack_delay = 2;
    i_BaseAddr = 32'h5000_0000; i_FrameLen = 16'd4;
    b0 = beats_seen; d0 = done_cnt; a0 = abort_cnt;
    add_entry(32'h5000_0000, 4);
    add_entry(32'h5000_0010, 0);
    pulse_restart();
    wait_req(50, "endrop");
    @(negedge HCLK);
    i_Enable = 1'b0;
    wait_idle(500, "endrop");
    chk("endrop_beats", 64'(beats_seen - b0), 64'd4);
    chk("endrop_done", 64'(done_cnt - d0), 64'd0);
    chk("endrop_abort", 64'(abort_cnt - a0), 64'd0);
    chk("endrop_fifo_left", 64'(fifo_q.size()), 64'd1);
    pulse_restart();
    repeat (5) @(negedge HCLK);
    #2;
    chk("disabled_restart_busy", 64'(o_Busy), 64'd0);
    chk("disabled_restart_fifo", 64'(fifo_q.size()), 64'd1);
    @(negedge HCLK);
    fifo_q.delete();
    i_Enable = 1'b1;

    // len=0 frame wraps the address space; reset lands mid-beat.
    $display("corner: len=0 wrap then reset mid-beat");
    ack_delay = 0;
    i_BaseAddr = 32'hFFFF_FFF0; i_FrameLen = 16'd0;
    b0 = beats_seen; d0 = done_cnt; a0 = abort_cnt;
    add_entry(32'hFFFF_FFF0, 4);
    add_entry(32'h0000_0000, 4);
    pulse_restart();
    wait_beats(b0 + 8, 200, "wrap");
    repeat (3) @(negedge HCLK);
    #2;
    chk("wrap_busy", 64'(o_Busy), 64'd1);
    chk("wrap_no_done", 64'(done_cnt - d0), 64'd0);
    chk("wrap_sb_left", 64'(sb.size()), 64'd0);
    ack_delay = 2;
    add_entry(32'h0000_0010, 0);
    wait_req(50, "midreset");
    @(negedge HCLK);
    HReset_N = 1'b0;
    @(negedge HCLK);
    #2;
    chk_reset_outputs("midreset");
    HReset_N = 1'b1;
    fifo_q.delete();
    repeat (3) @(negedge HCLK);
    #2;
    chk("post_reset_busy", 64'(o_Busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
